// File: rtl/mem_access_queue_pkg.sv
// Shared types for the memory access queue: access size, entry state and the
// per-request entry record (sized for the widest supported data bus).
package mem_access_params;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned BYTES          = DEF_DATA_WIDTH / 8;
  localparam int unsigned OFS_W          = $clog2(BYTES);
  localparam int unsigned MAX_DATA_W     = 64;
  localparam int unsigned MAX_BYTES      = MAX_DATA_W / 8;
  localparam int unsigned MAX_OFS_W      = $clog2(MAX_BYTES);

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } size_e;

  typedef enum logic {
    ENT_WAIT = 1'b0,
    ENT_DONE = 1'b1
  } ent_state_e;

  typedef struct packed {
    logic                   is_load;
    size_e                  size;
    logic                   is_unsigned;
    logic                   left;
    logic                   right;
    logic [MAX_OFS_W-1:0]   offset;
    ent_state_e             state;
    logic [MAX_DATA_W-1:0]  data;
    logic [MAX_BYTES-1:0]   strobe;
  } entry_t;

endpackage

// File: rtl/mem_access_queue_align.sv
// Combinational load extraction: picks the addressed lane, extends it, or
// performs the lwl/lwr-style partial merge shifts with matching byte strobes.
module load_align #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]             raw,
  input  logic                              is_load,
  input  logic [1:0]                        size,
  input  logic                              is_unsigned,
  input  logic                              left,
  input  logic                              right,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   offset,
  output logic [DATA_WIDTH-1:0]             data,
  output logic [DATA_WIDTH/8-1:0]           strobe
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] low_mask;
  logic [6:0]            nbits;
  logic                  sign_bit;

  always_comb begin
    lane     = raw >> {offset, 3'b000};
    nbits    = 7'd8 << size;
    low_mask = ~({DATA_WIDTH{1'b1}} << nbits);
    // Top bit of the selected lane (lane MSB sits where low_mask ends).
    sign_bit = |(lane & low_mask & ~(low_mask >> 1));
    data     = '0;
    strobe   = '0;
    if (is_load) begin
      if (left) begin
        data   = raw << {~offset, 3'b000};
        strobe = {NUM_BYTES{1'b1}} << ~offset;
      end else if (right) begin
        data   = lane;
        strobe = {NUM_BYTES{1'b1}} >> offset;
      end else begin
        data   = (lane & low_mask) | ((!is_unsigned && sign_bit) ? ~low_mask : '0);
        strobe = '1;
      end
    end
  end

endmodule

// File: rtl/mem_access_queue.sv
// In-order outstanding data-SRAM request tracker with response capture, load
// alignment and flush orphaning. MEM_ACCESS_QUEUE_BYPASS_EN enables same-cycle
// response forwarding to the head.
module mem_access_queue
  import mem_access_params::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_is_load,
  input  logic [1:0]                       req_size,
  input  logic                             req_unsigned,
  input  logic                             req_left,
  input  logic                             req_right,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]  req_offset,
  input  logic                             resp_valid,
  input  logic [DATA_WIDTH-1:0]            resp_data,
  input  logic                             flush,
  output logic                             head_valid,
  output logic                             head_is_load,
  output logic [DATA_WIDTH-1:0]            head_data,
  output logic [DATA_WIDTH/8-1:0]          head_strobe,
  input  logic                             head_pop,
  output logic [CNT_W-1:0]                 outstanding,
  output logic                             protocol_error
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFS_WIDTH = $clog2(NUM_BYTES);
  localparam int unsigned PTR_W     = $clog2(DEPTH);

  entry_t             q [DEPTH];
  logic [PTR_W-1:0]   rd, wr, rp;
  logic [CNT_W-1:0]   cnt, wcnt, orph;

  logic push, has_wait, has_orph, orph_drop, cap, err, head_done;
  logic pop, bypass_hit, bypass_pop;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [NUM_BYTES-1:0]  cap_strobe;
  entry_t                new_entry;

  assign has_wait  = wcnt != '0;
  assign has_orph  = orph != '0;
  assign head_done = cnt != wcnt;
  assign req_ready = ((CNT_W+1)'(cnt) + (CNT_W+1)'(orph)) < (CNT_W+1)'(DEPTH);
  assign outstanding = cnt + orph;
  assign push      = req_valid & req_ready;
  assign orph_drop = resp_valid & has_orph;
  assign cap       = resp_valid & ~has_orph & has_wait;
  assign err       = resp_valid & ~has_orph & ~has_wait;
  assign pop       = head_pop & head_valid & ~flush;
  assign bypass_pop = pop & bypass_hit;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_cap_align (
    .raw         (resp_data),
    .is_load     (q[rp].is_load),
    .size        (q[rp].size),
    .is_unsigned (q[rp].is_unsigned),
    .left        (q[rp].left),
    .right       (q[rp].right),
    .offset      (OFS_WIDTH'(q[rp].offset)),
    .data        (cap_data),
    .strobe      (cap_strobe)
  );

`ifdef MEM_ACCESS_QUEUE_BYPASS_EN
  logic [DATA_WIDTH-1:0] byp_data;
  logic [NUM_BYTES-1:0]  byp_strobe;

  // Head is the oldest WAIT entry exactly when no DONE entries precede it.
  assign bypass_hit = resp_valid & ~flush & ~has_orph & has_wait & ~head_done;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_byp_align (
    .raw         (resp_data),
    .is_load     (q[rd].is_load),
    .size        (q[rd].size),
    .is_unsigned (q[rd].is_unsigned),
    .left        (q[rd].left),
    .right       (q[rd].right),
    .offset      (OFS_WIDTH'(q[rd].offset)),
    .data        (byp_data),
    .strobe      (byp_strobe)
  );
`else
  assign bypass_hit = 1'b0;
`endif

  // Head presentation; zero whenever nothing is valid.
  always_comb begin
    head_valid   = head_done | bypass_hit;
    head_is_load = 1'b0;
    head_data    = '0;
    head_strobe  = '0;
    if (head_done) begin
      head_is_load = q[rd].is_load;
      head_data    = DATA_WIDTH'(q[rd].data);
      head_strobe  = NUM_BYTES'(q[rd].strobe);
    end
`ifdef MEM_ACCESS_QUEUE_BYPASS_EN
    else if (bypass_hit) begin
      head_is_load = q[rd].is_load;
      head_data    = byp_data;
      head_strobe  = byp_strobe;
    end
`endif
  end

  always_comb begin
    new_entry             = '0;
    new_entry.is_load     = req_is_load;
    new_entry.size        = size_e'(req_size);
    new_entry.is_unsigned = req_unsigned;
    new_entry.left        = req_left;
    new_entry.right       = req_right;
    new_entry.offset      = MAX_OFS_W'(req_offset);
    new_entry.state       = ENT_WAIT;
  end

  // Entry storage; flushed entries are simply abandoned by the pointer reset.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      if (push) q[wr] <= new_entry;
      if (cap && !bypass_pop) begin
        q[rp].state  <= ENT_DONE;
        q[rp].data   <= MAX_DATA_W'(cap_data);
        q[rp].strobe <= MAX_BYTES'(cap_strobe);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd             <= '0;
      wr             <= '0;
      rp             <= '0;
      cnt            <= '0;
      wcnt           <= '0;
      orph           <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (err) protocol_error <= 1'b1;
      if (flush) begin
        rd   <= '0;
        wr   <= '0;
        rp   <= '0;
        cnt  <= '0;
        wcnt <= '0;
        orph <= orph - CNT_W'(orph_drop) + (wcnt - CNT_W'(cap)) + CNT_W'(push);
      end else begin
        if (push) wr <= wr + PTR_W'(1);
        if (cap)  rp <= rp + PTR_W'(1);
        if (pop)  rd <= rd + PTR_W'(1);
        if (orph_drop) orph <= orph - CNT_W'(1);
        cnt  <= cnt + CNT_W'(push) - CNT_W'(pop);
        wcnt <= wcnt + CNT_W'(push) - CNT_W'(cap);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_queue.sv
// Self-checking bench for mem_access_queue: queue-based reference model checked
// every cycle, plus directed literal expectations.
module tb_mem_access_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_is_load, req_unsigned, req_left, req_right;
  logic [1:0]       req_size, req_offset;
  logic             resp_valid;
  logic [DW-1:0]    resp_data;
  logic             flush;
  logic             head_valid, head_is_load, head_pop;
  logic [DW-1:0]    head_data;
  logic [3:0]       head_strobe;
  logic [CNT_W-1:0] outstanding;
  logic             protocol_error;

  always #5 clock = ~clock;

  mem_access_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_left(req_left),
    .req_right(req_right), .req_offset(req_offset),
    .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
    .head_valid(head_valid), .head_is_load(head_is_load), .head_data(head_data),
    .head_strobe(head_strobe), .head_pop(head_pop),
    .outstanding(outstanding), .protocol_error(protocol_error)
  );

  typedef struct {
    bit        is_load;
    bit [1:0]  size;
    bit        uns, left, right;
    bit [1:0]  ofs;
    bit        done;
    bit [31:0] data;
    bit [3:0]  strobe;
  } rec_t;

  rec_t mq[$];
  int   orph = 0;
  bit   perr = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-wise reference of the load extraction rules; returns {strobe, data}.
  function automatic bit [35:0] ref_align(input bit [31:0] raw, input bit is_load,
      input bit [1:0] size, input bit uns, input bit left, input bit right, input bit [1:0] ofs);
    bit [7:0] b[4];
    bit [7:0] o[4];
    bit [3:0] s;
    bit [7:0] ext;
    int k, n;
    k = int'(ofs);
    s = 4'b0;
    for (int i = 0; i < 4; i++) begin
      b[i] = raw[8*i +: 8];
      o[i] = 8'h00;
    end
    if (!is_load) return 36'd0;
    if (left) begin
      for (int i = 0; i < 4; i++)
        if (i >= 3 - k) begin o[i] = b[i - (3 - k)]; s[i] = 1'b1; end
    end else if (right) begin
      for (int i = 0; i < 4; i++)
        if (i + k <= 3) begin o[i] = b[i + k]; s[i] = 1'b1; end
    end else begin
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      ext = 8'h00;
      if (!uns && (k + n - 1 <= 3) && b[k + n - 1][7]) ext = 8'hFF;
      for (int i = 0; i < 4; i++)
        o[i] = (i < n) ? ((k + i <= 3) ? b[k + i] : 8'h00) : ext;
      s = 4'hF;
    end
    return {s, o[3], o[2], o[1], o[0]};
  endfunction

  function automatic bit model_bypass();
`ifdef MEM_ACCESS_QUEUE_BYPASS_EN
    return resp_valid && !flush && orph == 0 && mq.size() > 0 && !mq[0].done;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model update on each active edge.
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      orph = 0;
      perr = 0;
    end else begin
      bit ready, push, hv;
      int idx;
      rec_t r;
      bit [35:0] al;
      ready = (mq.size() + orph) < DEPTH;
      push  = req_valid && ready;
      hv    = (mq.size() > 0 && mq[0].done) || model_bypass();
      if (resp_valid) begin
        if (orph > 0) orph--;
        else begin
          idx = -1;
          for (int i = 0; i < mq.size(); i++)
            if (!mq[i].done && idx < 0) idx = i;
          if (idx >= 0) begin
            al = ref_align(resp_data, mq[idx].is_load, mq[idx].size, mq[idx].uns,
                           mq[idx].left, mq[idx].right, mq[idx].ofs);
            mq[idx].done   = 1'b1;
            mq[idx].data   = al[31:0];
            mq[idx].strobe = al[35:32];
          end else perr = 1'b1;
        end
      end
      if (flush) begin
        for (int i = 0; i < mq.size(); i++)
          if (!mq[i].done) orph++;
        if (push) orph++;
        mq.delete();
      end else begin
        if (hv && head_pop) void'(mq.pop_front());
        if (push) begin
          r.is_load = req_is_load; r.size = req_size; r.uns = req_unsigned;
          r.left = req_left; r.right = req_right; r.ofs = req_offset;
          r.done = 1'b0; r.data = 32'd0; r.strobe = 4'd0;
          mq.push_back(r);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      bit hv, il;
      bit [31:0] ed;
      bit [3:0] es;
      bit [35:0] al;
      hv = 1'b0; il = 1'b0; ed = 32'd0; es = 4'd0;
      if (mq.size() > 0 && mq[0].done) begin
        hv = 1'b1; il = mq[0].is_load; ed = mq[0].data; es = mq[0].strobe;
      end else if (model_bypass()) begin
        al = ref_align(resp_data, mq[0].is_load, mq[0].size, mq[0].uns,
                       mq[0].left, mq[0].right, mq[0].ofs);
        hv = 1'b1; il = mq[0].is_load; ed = al[31:0]; es = al[35:32];
      end
      check("cyc_head_valid", 64'(head_valid), 64'(hv));
      check("cyc_head_is_load", 64'(head_is_load), 64'(il));
      check("cyc_head_data", 64'(head_data), 64'(ed));
      check("cyc_head_strobe", 64'(head_strobe), 64'(es));
      check("cyc_outstanding", 64'(outstanding), 64'(mq.size() + orph));
      check("cyc_req_ready", 64'(req_ready), 64'((mq.size() + orph) < DEPTH));
      check("cyc_protocol_error", 64'(protocol_error), 64'(perr));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    req_valid = 1'b0; resp_valid = 1'b0; flush = 1'b0; head_pop = 1'b0;
  endtask

  task automatic set_req(input bit is_load, input bit [1:0] size, input bit uns,
                         input bit l, input bit r, input bit [1:0] ofs);
    req_valid = 1'b1; req_is_load = is_load; req_size = size; req_unsigned = uns;
    req_left = l; req_right = r; req_offset = ofs;
  endtask

  task automatic load_case(input string name, input bit [1:0] size, input bit uns,
                           input bit l, input bit r, input bit [1:0] ofs,
                           input bit [31:0] raw, input bit [31:0] exp_d, input bit [3:0] exp_s);
    set_req(1'b1, size, uns, l, r, ofs);
    tick();
    resp_valid = 1'b1; resp_data = raw;
    tick();
    check({name, "_valid"}, 64'(head_valid), 64'(1));
    check({name, "_data"}, 64'(head_data), 64'(exp_d));
    check({name, "_strobe"}, 64'(head_strobe), 64'(exp_s));
    head_pop = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_is_load = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_left = 1'b0; req_right = 1'b0; req_offset = 2'd0;
    resp_valid = 1'b0; resp_data = 32'd0; flush = 1'b0; head_pop = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_head_valid", 64'(head_valid), 64'(0));
    check("rst_head_data", 64'(head_data), 64'(0));
    check("rst_protocol_error", 64'(protocol_error), 64'(0));

    // Word load: one-cycle latency then pop.
    set_req(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    check("lw_outstanding", 64'(outstanding), 64'(1));
    check("lw_not_ready_yet", 64'(head_valid), 64'(0));
    resp_valid = 1'b1; resp_data = 32'h8765_4321;
    tick();
    check("lw_valid", 64'(head_valid), 64'(1));
    check("lw_data", 64'(head_data), 64'(32'h8765_4321));
    check("lw_strobe", 64'(head_strobe), 64'(4'hF));
    head_pop = 1'b1;
    tick();
    check("lw_pop_outstanding", 64'(outstanding), 64'(0));

    load_case("lb", 2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'hF);
    load_case("lbu", 2'd0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h80FF_FFFF, 32'h0000_0080, 4'hF);
    load_case("lhu", 2'd1, 1'b1, 1'b0, 1'b0, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF, 4'hF);
    load_case("lh", 2'd1, 1'b0, 1'b0, 1'b0, 2'd2, 32'hBEEF_0000, 32'hFFFF_BEEF, 4'hF);
    load_case("lwl", 2'd2, 1'b0, 1'b1, 1'b0, 2'd1, 32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100);
    load_case("lwr", 2'd2, 1'b0, 1'b0, 1'b1, 2'd1, 32'hAABB_CCDD, 32'h00AA_BBCC, 4'b0111);

    // Store: response clears it, no register write.
    set_req(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    resp_valid = 1'b1; resp_data = 32'h1234_5678;
    tick();
    check("st_valid", 64'(head_valid), 64'(1));
    check("st_is_load", 64'(head_is_load), 64'(0));
    check("st_data", 64'(head_data), 64'(0));
    check("st_strobe", 64'(head_strobe), 64'(0));
    head_pop = 1'b1;
    tick();

    // Fill to DEPTH, refuse a fifth, then resp+pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
      tick();
    end
    check("full_ready", 64'(req_ready), 64'(0));
    set_req(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    check("full_outstanding", 64'(outstanding), 64'(4));
    resp_valid = 1'b1; resp_data = 32'hA000_0000;
    tick();
    resp_valid = 1'b1; resp_data = 32'hA000_0001; head_pop = 1'b1;
    tick();
    check("freed_ready", 64'(req_ready), 64'(1));
    check("freed_outstanding", 64'(outstanding), 64'(3));
    check("freed_head", 64'(head_data), 64'(32'hA000_0001));
    for (int j = 0; j < 3; j++) begin
      if (j < 2) begin resp_valid = 1'b1; resp_data = 32'hA000_0002 + 32'(j); end
      head_pop = 1'b1;
      tick();
    end
    check("drain_outstanding", 64'(outstanding), 64'(0));

    // Ten back-to-back loads to wrap the pointers.
    for (int i = 0; i < 12; i++) begin
      if (i < 10) set_req(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
      if (i >= 1 && i <= 10) begin resp_valid = 1'b1; resp_data = 32'h1000_0000 + 32'(i); end
      head_pop = 1'b1;
      tick();
    end
    check("wrap_outstanding", 64'(outstanding), 64'(0));

    // Flush with three WAIT entries plus simultaneous push and response.
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
      tick();
    end
    set_req(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    resp_valid = 1'b1; resp_data = 32'hDEAD_0000; flush = 1'b1; head_pop = 1'b1;
    tick();
    check("flush_orphans", 64'(outstanding), 64'(3));
    check("flush_head_valid", 64'(head_valid), 64'(0));
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1; resp_data = 32'hDEAD_0001 + 32'(i);
      tick();
      check("orphan_drop_valid", 64'(head_valid), 64'(0));
    end
    check("orphan_drained", 64'(outstanding), 64'(0));
    check("orphan_no_error", 64'(protocol_error), 64'(0));
    set_req(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    resp_valid = 1'b1; resp_data = 32'h4444_4444;
    tick();
    check("post_flush_data", 64'(head_data), 64'(32'h4444_4444));
    head_pop = 1'b1;
    tick();

`ifdef MEM_ACCESS_QUEUE_BYPASS_EN
    set_req(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    resp_valid = 1'b1; resp_data = 32'h0000_00F0; head_pop = 1'b1;
    #1;
    check("byp_valid", 64'(head_valid), 64'(1));
    check("byp_data", 64'(head_data), 64'(32'hFFFF_FFF0));
    tick();
    check("byp_retired", 64'(outstanding), 64'(0));
`endif

    // Reset mid-operation discards entries and orphans.
    set_req(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    set_req(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    flush = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_outstanding", 64'(outstanding), 64'(0));

    // Unsolicited response sets a sticky error.
    resp_valid = 1'b1; resp_data = 32'h0BAD_0BAD;
    tick();
    check("perr_set", 64'(protocol_error), 64'(1));
    repeat (3) tick();
    check("perr_held", 64'(protocol_error), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("perr_cleared", 64'(protocol_error), 64'(0));
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
